product_accumulator: RTL

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 55 +++++
 1 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN unsigned 8-bit products into an ACC_W-bit register with handshakes and sticky overflow
// ports: clk, rst_n (async active-low); start begins a run; product/in_valid/in_ready input handshake;
//        acc_out/out_valid/out_ready result handshake; overflow sticky carry-out; busy high outside IDLE
module product_accumulator #(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam logic [3:0] LAST = 4'(LEN - 1);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [ACC_W:0] sum;
  logic take;
  always_comb begin
    take = (state == ACCUM) && in_valid;
    sum = {1'b0, acc_out} + {{(ACC_W-7){1'b0}}, product};
    nxt = state == IDLE  ? (start ? ACCUM : IDLE) :
          state == ACCUM ? ((take && cnt == LAST) ? DONE : ACCUM) :
                           (out_ready ? IDLE : DONE);
  end
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc_out  <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        acc_out  <= '0;
        cnt      <= '0;
        overflow <= 1'b0;
      end else if (take) begin
        acc_out  <= sum[ACC_W-1:0];
        cnt      <= cnt + 4'd1;
        overflow <= overflow | sum[ACC_W];
      end
    end
  end
endmodule
